// File: rtl/step_ctrl_gen_if.sv
// Driver-side bundle for step_ctrl_gen: controls in, coil pins and status out.
// HALF exists only when STEP_HALF_EN is defined.
interface step_ctrl_gen_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
);
  logic             EN;
  logic [DIV_W-1:0] DIV;
  logic             SENSE;
  logic             OPP;
`ifdef STEP_HALF_EN
  logic             HALF;
`endif
  logic             STEP_A;
  logic             STEP_B;
  logic             STEP_AN;
  logic             STEP_BN;
  logic             DIR;
  logic             STEP_PULSE;
  logic [CNT_W-1:0] SENSE_CNT;

  modport master (
    output EN, DIV, SENSE, OPP,
`ifdef STEP_HALF_EN
    output HALF,
`endif
    input  STEP_A, STEP_B, STEP_AN, STEP_BN,
    input  DIR, STEP_PULSE, SENSE_CNT
  );

  modport slave (
    input  EN, DIV, SENSE, OPP,
`ifdef STEP_HALF_EN
    input  HALF,
`endif
    output STEP_A, STEP_B, STEP_AN, STEP_BN,
    output DIR, STEP_PULSE, SENSE_CNT
  );
endinterface

// File: rtl/step_ctrl_gen.sv
// Two-phase bipolar stepper phase generator with rate divider and auto-reversal.
// Define STEP_HALF_EN to add the HALF input and the 8-entry half-step table.
module step_ctrl_gen #(
  parameter int DIV_W     = 16,
  parameter int REV_LIMIT = 6,
  parameter int CNT_W     = 8
) (
  input  logic           CLK,
  input  logic           RESETN,
  step_ctrl_gen_if.slave bus
);

`ifdef STEP_HALF_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((REV_LIMIT > 0) ? REV_LIMIT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sense_s1_q, sense_s1_d;
  logic             sense_s2_q, sense_s2_d;
  logic             sense_d3_q, sense_d3_d;
  logic             opp_s1_q, opp_s1_d;
  logic             opp_s2_q, opp_s2_d;
  logic             opp_d3_q, opp_d3_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       pat_q, pat_d;
  logic             pulse_q, pulse_d;
  logic             started_q, started_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sense_rise;
  logic             opp_edge;
  logic             tick;
  logic [IDX_W-1:0] step;

  function automatic logic [3:0] pat_lut(
    input logic [IDX_W-1:0] i
  );
    logic [3:0] p;
    p = 4'b0000;
`ifdef STEP_HALF_EN
    unique case (i)
      3'd0: p = 4'b1001;
      3'd1: p = 4'b1000;
      3'd2: p = 4'b1100;
      3'd3: p = 4'b0100;
      3'd4: p = 4'b0110;
      3'd5: p = 4'b0010;
      3'd6: p = 4'b0011;
      3'd7: p = 4'b0001;
      default: p = 4'b0000;
    endcase
`else
    unique case (i)
      2'd0: p = 4'b1001;
      2'd1: p = 4'b1100;
      2'd2: p = 4'b0110;
      2'd3: p = 4'b0011;
      default: p = 4'b0000;
    endcase
`endif
    return p;
  endfunction

  always_comb begin
    sense_s1_d = bus.SENSE;
    sense_s2_d = sense_s1_q;
    sense_d3_d = sense_s2_q;
    opp_s1_d   = bus.OPP;
    opp_s2_d   = opp_s1_q;
    opp_d3_d   = opp_s2_q;
    sense_rise = sense_s2_q & ~sense_d3_q;
    opp_edge   = opp_s2_q ^ opp_d3_q;
  end

  // >= rather than == so a DIV lowered below the running count ticks at once
  always_comb begin
    tick    = 1'b0;
    timer_d = timer_q;
    if (!bus.EN) begin
      timer_d = '0;
    end else if (timer_q >= bus.DIV) begin
      tick    = 1'b1;
      timer_d = '0;
    end else begin
      timer_d = timer_q + DIV_W'(1);
    end
  end

  // Half mode leaves an odd index with a single step to realign on full steps
  always_comb begin
`ifdef STEP_HALF_EN
    step = (bus.HALF || idx_q[0]) ? 3'd1 : 3'd2;
`else
    step = 2'd1;
`endif
  end

  always_comb begin
    idx_d     = idx_q;
    pat_d     = pat_q;
    pulse_d   = 1'b0;
    started_d = started_q;
    if (tick) begin
      pulse_d   = 1'b1;
      started_d = 1'b1;
      if (started_q) begin
        idx_d = dir_q ? idx_q + step : idx_q - step;
      end
      pat_d = pat_lut(idx_d);
    end
  end

  always_comb begin
    dir_d = dir_q;
    cnt_d = cnt_q;
    if (opp_edge) begin
      dir_d = ~dir_q;
      cnt_d = '0;
    end else if (sense_rise) begin
      if (REV_LIMIT != 0 && cnt_q == CNT_LAST) begin
        dir_d = ~dir_q;
        cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Sync chain reloads live levels in reset so release shows no false edge
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      sense_s1_q <= bus.SENSE;
      sense_s2_q <= bus.SENSE;
      sense_d3_q <= bus.SENSE;
      opp_s1_q   <= bus.OPP;
      opp_s2_q   <= bus.OPP;
      opp_d3_q   <= bus.OPP;
      timer_q    <= '0;
      idx_q      <= '0;
      pat_q      <= 4'b0000;
      pulse_q    <= 1'b0;
      started_q  <= 1'b0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sense_s1_q <= sense_s1_d;
      sense_s2_q <= sense_s2_d;
      sense_d3_q <= sense_d3_d;
      opp_s1_q   <= opp_s1_d;
      opp_s2_q   <= opp_s2_d;
      opp_d3_q   <= opp_d3_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      pat_q      <= pat_d;
      pulse_q    <= pulse_d;
      started_q  <= started_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.STEP_A     = pat_q[3];
  assign bus.STEP_B     = pat_q[2];
  assign bus.STEP_AN    = pat_q[1];
  assign bus.STEP_BN    = pat_q[0];
  assign bus.DIR        = dir_q;
  assign bus.STEP_PULSE = pulse_q;
  assign bus.SENSE_CNT  = cnt_q;

endmodule

// File: doc/step_ctrl_gen.md
Name: step_ctrl_gen

Overview:
- Parametrised next-generation stepper-motor phase controller for the two-phase bipolar driver (A, B, AN, BN).
- Adds a programmable step-rate divider, an enable/hold input, and synchronised SENSE and OPP inputs with edge detection.
- Adds a configurable auto-reversal threshold, status outputs, and optional half-stepping.
- Sits between board switches/magnetic sensor and the motor driver pins, clocked from the system clock.

Parameters:
- DIV_W, 16: width of the step-period divider input DIV.
- REV_LIMIT, 6: SENSE rising edges that trigger auto-reversal; 0 disables auto-reversal.
- CNT_W, 8: width of the sense counter SENSE_CNT; must hold REV_LIMIT.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESETN  in  1  synchronous, active-low reset.
- EN  in  1  1 = stepping runs; 0 = hold current coil pattern.
- DIV  in  DIV_W  step period minus 1, in CLK cycles. 0 gives one step per cycle.
- SENSE  in  1  asynchronous magnetic sensor pulse.
- OPP  in  1  asynchronous direction switch; any level change reverses direction.
- HALF  in  1  half-step select; present only with STEP_HALF_EN.
- STEP_A, STEP_B, STEP_AN, STEP_BN  out  1 each  coil drive, pattern bits [3:0] in that order.
- DIR  out  1  current direction; 1 = forward.
- STEP_PULSE  out  1  one-cycle strobe, high in the cycle the pattern changes.
- SENSE_CNT  out  CNT_W  SENSE edges counted since the last reversal or reset.

Behaviour:
- Reset (RESETN=0 at a CLK edge):
  - coil pattern 0000; DIR=0; index=0; timer=0; SENSE_CNT=0; STEP_PULSE=0; started flag=0.
  - Sync flops load the current SENSE/OPP levels, so no edge is detected at reset release.
- Synchronisers: SENSE and OPP each pass through 2 flops, then 1 edge-detect flop.
  - A SENSE rise seen at CLK edge n updates SENSE_CNT/DIR at edge n+2.
- Rate timer:
  - While EN=1, timer increments each cycle.
  - When timer >= DIV: tick, timer returns to 0. The >= compare means a live DIV decrease below the timer ticks on the next cycle.
  - EN=0: timer cleared to 0, pattern held, no tick.
- First tick after reset: drive the pattern for the current index (0 → 1001) without advancing; set started flag.
- Later ticks: index += 1 if DIR=1, else index -= 1, wrapping modulo table size.
- Pattern and STEP_PULSE are registered. Both update in the tick cycle + 1 and stay aligned.
- Full-step table, index 0..3: 1001, 1100, 0110, 0011.
- Reversal sources, evaluated each cycle:
  - OPP edge (either polarity): toggle DIR; SENSE_CNT=0.
  - SENSE rising edge with REV_LIMIT≠0 and SENSE_CNT == REV_LIMIT-1: toggle DIR; SENSE_CNT=0.
  - Other SENSE rising edges: SENSE_CNT += 1, saturating at all-ones when REV_LIMIT=0.
  - OPP edge and SENSE edge in the same cycle: exactly one toggle; SENSE_CNT=0.
- A DIR change takes effect at the next tick. No pattern change happens at the moment of reversal.
- Reset mid-run: coils de-energise immediately, in the same edge, with no extra tick.

Optional Feature:
- Macro: STEP_HALF_EN.
- Defined:
  - HALF port exists; index is 3 bits with an 8-entry table: 1001, 1000, 1100, 0100, 0110, 0010, 0011, 0001.
  - HALF=1 steps by 1 through all 8 entries. HALF=0 steps by 2 through the even entries, which equal the full-step table.
  - HALF toggled to 0 while index is odd: the next tick moves by 1 in the current direction, landing on an even index. Stepping by 2 resumes after that.
- Undefined: no HALF port; 2-bit index; full-step table only.

Test Plan:
- Reset, then EN=1, DIV=3, OPP static → first STEP_PULSE with pattern 1001; then 0011, 0110, 1100, 1001 (DIR=0), one per 4 cycles.
- DIV=0, toggle OPP after 3 steps → DIR=1 about 3 cycles later; SENSE_CNT=0; next tick reverses the sequence order with no repeated or skipped pattern.
- REV_LIMIT=6, 6 SENSE pulses each ≥3 cycles wide → SENSE_CNT 1..5, then DIR toggles and SENSE_CNT=0 on the 6th pulse.
- OPP edge and 6th SENSE edge arranged to be detected in the same cycle → DIR toggles once; SENSE_CNT=0.
- EN=0 mid-run for 20 cycles → pattern held, no STEP_PULSE. Re-assert EN=1, DIV=3 → next pulse 4 cycles later.
- With STEP_HALF_EN: HALF=1, DIR=1 → 1001, 1000, 1100, 0100… Set HALF=0 at index 3 → next pattern 0110, then 0011. Assert RESETN=0 mid-run → 0000 at the next edge.
